// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with EX-stage forwarding select and load-use detection.
// Latency: one cycle input-to-output; forwarding select and LoadUseStall are combinational.
// Backpressure: Stall holds every field, Flush squashes to a bubble (Flush wins); load-use and halt insert bubbles.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   AluResIn, RtIn            ALU result and store data from execute
//   ValidIn, *In control      execute-stage instruction and its memory/writeback control
//   RdAddrIn                  destination register of the execute instruction
//   ExRsAddr/ExRtAddr/*Used   source registers read by the instruction now in execute
//   WbRegWrite, WbRdAddr      MEM/WB destination, used as the second forwarding source
//   Stall, Flush              hold / squash requests
//   *Out                      registered fields driven into the memory stage
//   FwdRsSel, FwdRtSel        00 none, 01 EX/MEM AluResOut, 10 MEM/WB
//   LoadUseStall              execute must hold one cycle behind a load
//   Halted                    sticky flag set once a dump leaves this stage
module ex_mem_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] AluResIn,
  input  logic [DATA_W-1:0] RtIn,
  input  logic              ValidIn,
  input  logic              RegWriteIn,
  input  logic              DMemWriteIn,
  input  logic              DMemEnIn,
  input  logic              MemToRegIn,
  input  logic              DMemDumpIn,
  input  logic [REG_AW-1:0] RdAddrIn,
  input  logic [REG_AW-1:0] ExRsAddr,
  input  logic [REG_AW-1:0] ExRtAddr,
  input  logic              ExRsUsed,
  input  logic              ExRtUsed,
  input  logic              WbRegWrite,
  input  logic [REG_AW-1:0] WbRdAddr,
  input  logic              Stall,
  input  logic              Flush,
  output logic [DATA_W-1:0] AluResOut,
  output logic [DATA_W-1:0] RtOut,
  output logic              RegWriteOut,
  output logic              DMemWriteOut,
  output logic              DMemEnOut,
  output logic              MemToRegOut,
  output logic              DMemDumpOut,
  output logic [REG_AW-1:0] RdAddrOut,
  output logic              ValidOut,
  output logic [1:0]        FwdRsSel,
  output logic [1:0]        FwdRtSel,
  output logic              LoadUseStall,
  output logic              Halted
);

  logic matchMRs, matchMRt, matchWRs, matchWRt;
  logic dumpLeaving;
  logic insertBubble;

  // rst gates the MEM/WB match so the select reads 00 throughout reset,
  // even if the writeback stage is still presenting a write.
  assign matchMRs = ValidOut & RegWriteOut & (RdAddrOut == ExRsAddr) & ExRsUsed;
  assign matchMRt = ValidOut & RegWriteOut & (RdAddrOut == ExRtAddr) & ExRtUsed;
  assign matchWRs = rst & WbRegWrite & (WbRdAddr == ExRsAddr) & ExRsUsed;
  assign matchWRt = rst & WbRegWrite & (WbRdAddr == ExRtAddr) & ExRtUsed;

  // A load in EX/MEM has no data yet, so a dependent consumer gets 00 and
  // waits; it picks the value up from MEM/WB one cycle later.
  always_comb begin
    FwdRsSel = 2'b00;
    if (matchMRs) begin
      FwdRsSel = MemToRegOut ? 2'b00 : 2'b01;
    end else if (matchWRs) begin
      FwdRsSel = 2'b10;
    end
  end

  always_comb begin
    FwdRtSel = 2'b00;
    if (matchMRt) begin
      FwdRtSel = MemToRegOut ? 2'b00 : 2'b01;
    end else if (matchWRt) begin
      FwdRtSel = 2'b10;
    end
  end

  assign LoadUseStall = (matchMRs | matchMRt) & MemToRegOut & ~Halted;

  assign dumpLeaving  = ValidOut & DMemDumpOut;
  assign insertBubble = Halted | dumpLeaving | LoadUseStall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AluResOut    <= '0;
      RtOut        <= '0;
      RegWriteOut  <= 1'b0;
      DMemWriteOut <= 1'b0;
      DMemEnOut    <= 1'b0;
      MemToRegOut  <= 1'b0;
      DMemDumpOut  <= 1'b0;
      RdAddrOut    <= '0;
      ValidOut     <= 1'b0;
    end else if (Flush || (!Stall && insertBubble)) begin
      AluResOut    <= '0;
      RtOut        <= '0;
      RegWriteOut  <= 1'b0;
      DMemWriteOut <= 1'b0;
      DMemEnOut    <= 1'b0;
      MemToRegOut  <= 1'b0;
      DMemDumpOut  <= 1'b0;
      RdAddrOut    <= '0;
      ValidOut     <= 1'b0;
    end else if (!Stall) begin
      AluResOut    <= AluResIn;
      RtOut        <= RtIn;
      RegWriteOut  <= RegWriteIn & ValidIn;
      DMemWriteOut <= DMemWriteIn & ValidIn;
      DMemEnOut    <= DMemEnIn & ValidIn;
      MemToRegOut  <= MemToRegIn & ValidIn;
      DMemDumpOut  <= DMemDumpIn & ValidIn;
      RdAddrOut    <= RdAddrIn;
      ValidOut     <= ValidIn;
    end
  end

  // A dump only counts as retired when it actually advances; a squashed or
  // held dump leaves Halted alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Halted <= 1'b0;
    end else if (dumpLeaving && !Stall && !Flush) begin
      Halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] AluResIn, RtIn;
  logic        ValidIn, RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn;
  logic [2:0]  RdAddrIn, ExRsAddr, ExRtAddr, WbRdAddr;
  logic        ExRsUsed, ExRtUsed, WbRegWrite, Stall, Flush;
  logic [15:0] AluResOut, RtOut;
  logic        RegWriteOut, DMemWriteOut, DMemEnOut, MemToRegOut, DMemDumpOut;
  logic [2:0]  RdAddrOut;
  logic        ValidOut;
  logic [1:0]  FwdRsSel, FwdRtSel;
  logic        LoadUseStall, Halted;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst),
    .AluResIn(AluResIn), .RtIn(RtIn), .ValidIn(ValidIn),
    .RegWriteIn(RegWriteIn), .DMemWriteIn(DMemWriteIn), .DMemEnIn(DMemEnIn),
    .MemToRegIn(MemToRegIn), .DMemDumpIn(DMemDumpIn), .RdAddrIn(RdAddrIn),
    .ExRsAddr(ExRsAddr), .ExRtAddr(ExRtAddr), .ExRsUsed(ExRsUsed), .ExRtUsed(ExRtUsed),
    .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr), .Stall(Stall), .Flush(Flush),
    .AluResOut(AluResOut), .RtOut(RtOut), .RegWriteOut(RegWriteOut),
    .DMemWriteOut(DMemWriteOut), .DMemEnOut(DMemEnOut), .MemToRegOut(MemToRegOut),
    .DMemDumpOut(DMemDumpOut), .RdAddrOut(RdAddrOut), .ValidOut(ValidOut),
    .FwdRsSel(FwdRsSel), .FwdRtSel(FwdRtSel), .LoadUseStall(LoadUseStall), .Halted(Halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] rt,
                       input logic rw, input logic dw, input logic de, input logic m2r,
                       input logic dump, input logic [2:0] rd);
    ValidIn = v; AluResIn = alu; RtIn = rt; RegWriteIn = rw; DMemWriteIn = dw;
    DMemEnIn = de; MemToRegIn = m2r; DMemDumpIn = dump; RdAddrIn = rd;
  endtask

  task automatic clearHazardInputs();
    ExRsAddr = 3'd0; ExRtAddr = 3'd0; ExRsUsed = 1'b0; ExRtUsed = 1'b0;
    WbRegWrite = 1'b0; WbRdAddr = 3'd0;
  endtask

  initial begin
    rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    clearHazardInputs();
    #1;
    chk("rst_valid", ValidOut, 0);
    chk("rst_alures", AluResOut, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_lus", LoadUseStall, 0);
    #11 rst = 1'b1;

    // Plain ALU op
    drive(1'b1, 16'h1234, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    tick();
    chk("alu_res", AluResOut, 16'h1234);
    chk("alu_rd", RdAddrOut, 3);
    chk("alu_rw", RegWriteOut, 1);
    chk("alu_valid", ValidOut, 1);

    // Reset asserted mid-cycle clears everything at once
    #3 rst = 1'b0;
    #1;
    chk("midrst_alures", AluResOut, 0);
    chk("midrst_valid", ValidOut, 0);
    chk("midrst_rw", RegWriteOut, 0);
    chk("midrst_rd", RdAddrOut, 0);
    rst = 1'b1;
    tick();
    chk("relrst_alures", AluResOut, 16'h1234);
    chk("relrst_valid", ValidOut, 1);

    // Forwarding priority: ALU op writing r2 in EX/MEM
    drive(1'b1, 16'h0222, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    tick();
    ExRsAddr = 3'd2; ExRsUsed = 1'b1; WbRegWrite = 1'b1; WbRdAddr = 3'd2;
    ExRtAddr = 3'd2; ExRtUsed = 1'b0;
    #1;
    chk("fwd_rs_mem_over_wb", FwdRsSel, 2'b01);
    chk("fwd_rt_unused", FwdRtSel, 2'b00);
    chk("fwd_no_lus", LoadUseStall, 0);
    ExRtAddr = 3'd4; ExRtUsed = 1'b1; WbRdAddr = 3'd4;
    #1;
    chk("fwd_rt_wb", FwdRtSel, 2'b10);
    chk("fwd_rs_mem_still", FwdRsSel, 2'b01);
    clearHazardInputs();

    // Load-use: load to r5, then consumer reads r5 as Rt
    drive(1'b1, 16'h0500, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5);
    tick();
    chk("ld_m2r", MemToRegOut, 1);
    ExRtAddr = 3'd5; ExRtUsed = 1'b1;
    drive(1'b1, 16'h0600, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6);
    #1;
    chk("lu_stall", LoadUseStall, 1);
    chk("lu_fwd_rt", FwdRtSel, 2'b00);
    tick();
    chk("lu_bubble_valid", ValidOut, 0);
    chk("lu_bubble_rw", RegWriteOut, 0);
    chk("lu_bubble_m2r", MemToRegOut, 0);
    chk("lu_bubble_den", DMemEnOut, 0);
    chk("lu_bubble_alures", AluResOut, 0);
    chk("lu_cleared", LoadUseStall, 0);
    WbRegWrite = 1'b1; WbRdAddr = 3'd5;
    #1;
    chk("lu_fwd_wb", FwdRtSel, 2'b10);
    tick();
    chk("lu_resume_rd", RdAddrOut, 6);
    chk("lu_resume_valid", ValidOut, 1);
    clearHazardInputs();

    // Stall during load-use keeps the load and the stall request
    drive(1'b1, 16'h0505, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5);
    tick();
    ExRtAddr = 3'd5; ExRtUsed = 1'b1; Stall = 1'b1;
    #1;
    chk("lus_stall_pre", LoadUseStall, 1);
    tick();
    chk("lus_stall_valid", ValidOut, 1);
    chk("lus_stall_alures", AluResOut, 16'h0505);
    chk("lus_stall_held", LoadUseStall, 1);
    Stall = 1'b0;
    clearHazardInputs();

    // Store held under Stall, then Stall+Flush bubbles it
    drive(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("st_dw", DMemWriteOut, 1);
    chk("st_rt", RtOut, 16'hBEEF);
    drive(1'b1, 16'hFFFF, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rt", RtOut, 16'hBEEF);
      chk("stall_dw", DMemWriteOut, 1);
      chk("stall_alures", AluResOut, 16'h0010);
    end
    Flush = 1'b1;
    tick();
    chk("flush_valid", ValidOut, 0);
    chk("flush_dw", DMemWriteOut, 0);
    chk("flush_rt", RtOut, 0);
    Stall = 1'b0; Flush = 1'b0;

    // Bubble input: controls masked by ValidIn, data still loaded
    drive(1'b0, 16'h5555, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    tick();
    chk("bub_rw", RegWriteOut, 0);
    chk("bub_dw", DMemWriteOut, 0);
    chk("bub_valid", ValidOut, 0);
    chk("bub_alures", AluResOut, 16'h5555);

    // Halt after a dump retires
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    chk("dump_loaded", DMemDumpOut, 1);
    chk("dump_not_halted", Halted, 0);
    drive(1'b1, 16'h1234, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    tick();
    chk("halt_valid", ValidOut, 0);
    chk("halt_set", Halted, 1);
    tick();
    chk("halt_hold_valid", ValidOut, 0);
    chk("halt_hold_rw", RegWriteOut, 0);
    chk("halt_sticky", Halted, 1);
    rst = 1'b0;
    #1;
    chk("halt_rst", Halted, 0);
    rst = 1'b1;

    // Flushed dump does not halt
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    chk("dump2_loaded", DMemDumpOut, 1);
    drive(1'b1, 16'h1234, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    Flush = 1'b1;
    tick();
    chk("fdump_halted", Halted, 0);
    chk("fdump_valid", ValidOut, 0);
    Flush = 1'b0;
    tick();
    chk("fdump_resume_valid", ValidOut, 1);
    chk("fdump_resume_halted", Halted, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
